piso_stream_serializer: RTL
===========================

Name: piso_stream_serializer

Overview:
- Parametrised parallel-in/serial-out serializer that succeeds the fixed 4-bit load/shift PISO.
- Accepts an N-bit word over a valid/ready handshake and shifts it out one bit per enabled clock, MSB-first or LSB-first.
- Marks each serial bit with valid and last flags and supports back-to-back words with no gap cycle.
- Sits between a parallel data source (register file, FIFO) and a bit-serial link or shift chain.

Parameters:
- N, 8, word width in bits; legal range N >= 1.
- MSB_FIRST, 1, bit order: 1 = bit N-1 goes out first, 0 = bit 0 goes out first.
- IDLE_LEVEL, 1'b0, value driven on so when no word is being shifted.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  source offers in_data.
- in_ready  out  1  serializer can accept a word this cycle.
- in_data  in  N  parallel word; sampled only on handshake.
- shift_en  in  1  advance enable; 0 holds the current bit on so.
- so  out  1  serial data out.
- so_valid  out  1  so carries a word bit.
- so_last  out  1  so carries the final bit of the current word.
- busy  out  1  a word is in flight (identical to so_valid).

Behaviour:
- Reset is asynchronous. While reset_n = 0:
  - state = IDLE, shift register = 0, bit counter = 0.
  - so = IDLE_LEVEL, so_valid = 0, so_last = 0, busy = 0.
  - in_ready = 1, but no word is captured until the first rising edge after reset_n deasserts.
- State machine has two states, IDLE and SHIFT. Internal signals:
  - sreg[N-1:0] holds the word being shifted.
  - cnt, width max(1, clog2(N)), holds the number of bits remaining minus 1.
- Handshake: a word is accepted at a rising edge when in_valid = 1 and in_ready = 1. At that edge:
  - sreg <= in_data, cnt <= N-1, state <= SHIFT.
- in_ready is combinational:
  - in_ready = (state == IDLE) OR (state == SHIFT AND cnt == 0 AND shift_en).
  - It does not depend on in_valid.
- Latency: a word accepted at edge k presents its first bit on so in the cycle after edge k.
- In SHIFT:
  - so = sreg[N-1] when MSB_FIRST = 1, else so = sreg[0].
  - so_valid = 1; so_last = (cnt == 0).
- At each edge in SHIFT with shift_en = 1:
  - If cnt != 0: sreg shifts toward the output end with zero fill, and cnt decrements.
  - If cnt == 0 and a new word is accepted: load the new word per the handshake rule; state stays SHIFT. There is no bubble cycle.
  - If cnt == 0 and no word is accepted: state <= IDLE.
- shift_en = 0 in SHIFT: sreg, cnt, so and so_last all hold. in_ready = 0 unless state is IDLE.
- In IDLE: so = IDLE_LEVEL, so_valid = 0, so_last = 0. shift_en is ignored.
- in_data changes while in SHIFT without a handshake are ignored; the word in flight is never corrupted.
- N = 1: every word occupies exactly one enabled cycle and so_last = so_valid.
- Reset mid-word: the word is abandoned and outputs return to their reset values immediately, with no clock edge required. No partial word resumes after reset.
- Throughput: with in_valid and shift_en held at 1, so_valid stays 1 continuously and a word completes every N cycles.

Test Plan:
All scenarios use N = 4 unless stated.
1. Reset and idle: reset_n pulsed low for 4 ns, asynchronous to clk -> so = 0, so_valid = 0, so_last = 0 and in_ready = 1 take effect during the low pulse itself, not at the next edge.
2. Single word, MSB_FIRST = 1: handshake in_data = 4'b1010, shift_en = 1 -> next 4 cycles so = 1,0,1,0 with so_valid = 1, so_last = 1 only on the 4th. The cycle after that is IDLE with so = IDLE_LEVEL.
3. Back-to-back: 4'b1010 accepted, then in_valid held with in_data = 4'b1111 -> in_ready = 1 only in the so_last cycle. so stream is 1,0,1,0,1,1,1,1 with no gap, and so_last is high in cycles 4 and 8.
4. Stall: word 4'b1100, shift_en dropped for 3 cycles after the 2nd bit -> so holds 1 for those 3 cycles and in_ready = 0 throughout. The sequence then completes as 0,0 with so_last on the final bit.
5. LSB-first instance (MSB_FIRST = 0, N = 8): in_data = 8'hA5 -> so = 1,0,1,0,0,1,0,1.
6. Reset mid-word: reset_n asserted after 2 bits of 4'b0110 -> so_valid = 0 immediately. After release the next accepted word 4'b1001 shifts cleanly as 1,0,0,1.

Source files
------------

// File: rtl/piso_stream_serializer.sv
// rtl/piso_stream_serializer.sv - parametrised valid/ready parallel-in serial-out serializer
//
// Accepts an N-bit word over a valid/ready handshake and shifts it out one bit
// per enabled clock, MSB-first or LSB-first, with back-to-back words and no gap.
//
// Parameters:
//   N          word width in bits (N >= 1)
//   MSB_FIRST  1: bit N-1 leaves first, 0: bit 0 leaves first
//   IDLE_LEVEL level driven on so while no word is being shifted
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   in_valid  in   source offers in_data
//   in_ready  out  serializer accepts a word this cycle (combinational)
//   in_data   in   parallel word, sampled only on handshake
//   shift_en  in   advance enable; 0 holds the current bit on so
//   so        out  serial data
//   so_valid  out  so carries a word bit
//   so_last   out  so carries the final bit of the current word
//   busy      out  a word is in flight (same as so_valid)

module piso_stream_serializer #(
    parameter int   N          = 8,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         shift_en,
    output logic         so,
    output logic         so_valid,
    output logic         so_last,
    output logic         busy
);

    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam bit MSB = (MSB_FIRST != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    sreg;
    logic [N-1:0]    sreg_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            last_bit;
    logic            accept;

    assign last_bit = (cnt == '0);

    // Ready either when idle or when the final bit is being consumed this
    // cycle, which is what lets the next word follow with no bubble.
    assign in_ready = (state == IDLE) || (last_bit && shift_en);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    sreg_nxt  = in_data;
                    cnt_nxt   = CW'(N - 1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (!last_bit) begin
                        // Zero fill from the far end keeps the vacated bits clean.
                        sreg_nxt = MSB ? (sreg << 1) : (sreg >> 1);
                        cnt_nxt  = cnt - CW'(1);
                    end else if (accept) begin
                        sreg_nxt = in_data;
                        cnt_nxt  = CW'(N - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode straight from state, so an asynchronous reset clears
    // them without waiting for a clock edge.
    assign so_valid = (state == SHIFT);
    assign busy     = so_valid;
    assign so_last  = so_valid && last_bit;
    assign so       = so_valid ? (MSB ? sreg[N-1] : sreg[0]) : IDLE_LEVEL;

endmodule
